// File: rtl/dmem_access_ctrl_pkg.sv
// dmem_access_ctrl_pkg: size codes, FSM states and alignment helper for the data-memory port
package dmem_access_ctrl_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  typedef enum logic [1:0] {DM_IDLE, DM_REQ, DM_WAIT, DM_DRAIN} dm_state_e;
  // size 11 is treated as a word
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] a);
    return size == SZ_B ? 1'b1 : size == SZ_H ? !a[0] : a == 2'b00;
  endfunction
endpackage

// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if: split-transaction SRAM-like bus (address phase, then data phase)
interface dmem_access_ctrl_if;
  logic        sram_req;
  logic        sram_wr;
  logic [1:0]  sram_size;
  logic [31:0] sram_addr;
  logic [3:0]  sram_wstrb;
  logic [31:0] sram_wdata;
  logic        sram_addr_ok;
  logic        sram_data_ok;
  logic [31:0] sram_rdata;
  modport master(output sram_req, sram_wr, sram_size, sram_addr, sram_wstrb, sram_wdata,
                 input sram_addr_ok, sram_data_ok, sram_rdata);
  modport slave(input sram_req, sram_wr, sram_size, sram_addr, sram_wstrb, sram_wdata,
                output sram_addr_ok, sram_data_ok, sram_rdata);
endinterface

// File: rtl/dmem_access_ctrl_align.sv
// dmem_align: byte-strobe generation, store-lane replication and load extraction/extension
module dmem_align
  import dmem_access_ctrl_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);
  logic [31:0] w;
  logic        sx;
  assign w = rdata_i >> {off_i, 3'b000};
  always_comb begin
    sx = !unsigned_i && (size_i == SZ_B ? w[7] : w[15]);
    wstrb_o = size_i == SZ_B ? 4'b0001 << off_i : size_i == SZ_H ? 4'b0011 << off_i : 4'b1111;
    wdata_o = size_i == SZ_B ? {4{wdata_i[7:0]}} : size_i == SZ_H ? {2{wdata_i[15:0]}} : wdata_i;
    rdata_o = size_i == SZ_B ? {{24{sx}}, w[7:0]} : size_i == SZ_H ? {{16{sx}}, w[15:0]} : w;
  end
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: EX->MEM load/store sequencer with stall request, misalignment detection and flush draining
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic        flush_i,
  output logic        stallreq_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        adel_o,
  output logic        ades_o,
  output logic [31:0] bad_vaddr_o,
  dmem_access_ctrl_if.master sram
);
  dm_state_e   state_q, state_d;
  logic        we_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        idle, aligned, accept;
  logic [3:0]  strb;
  logic [31:0] wrep, rext;
  assign idle    = state_q == DM_IDLE;
  assign aligned = is_aligned(req_size_i, req_addr_i[1:0]);
  assign accept  = idle && req_valid_i && !flush_i && aligned;
  // In IDLE the aligner shapes the incoming store; afterwards it extracts loads from the latched op
  dmem_align u_align (
    .size_i    (idle ? req_size_i : size_q),
    .off_i     (idle ? req_addr_i[1:0] : addr_q[1:0]),
    .unsigned_i(uns_q),
    .wdata_i   (req_wdata_i),
    .rdata_i   (sram.sram_rdata),
    .wstrb_o   (strb),
    .wdata_o   (wrep),
    .rdata_o   (rext)
  );
  always_ff @(posedge clk)
    state_q <= rst ? DM_IDLE : state_d;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DM_IDLE:  state_d = accept ? DM_REQ : DM_IDLE;
      DM_REQ:   state_d = sram.sram_addr_ok ? (flush_i ? DM_DRAIN : DM_WAIT) : (flush_i ? DM_IDLE : DM_REQ);
      DM_WAIT:  state_d = sram.sram_data_ok ? DM_IDLE : flush_i ? DM_DRAIN : DM_WAIT;
      DM_DRAIN: state_d = sram.sram_data_ok ? DM_IDLE : DM_DRAIN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (accept) begin
      we_q    <= req_we_i;
      uns_q   <= req_unsigned_i;
      size_q  <= req_size_i;
      addr_q  <= req_addr_i;
      wdata_q <= wrep;
      wstrb_q <= req_we_i ? strb : 4'b0000;
    end
  end
  always_comb begin
    stallreq_o   = accept || state_q == DM_REQ || (state_q == DM_WAIT && !sram.sram_data_ok) ||
                   (state_q == DM_DRAIN && req_valid_i);
    resp_valid_o = state_q == DM_WAIT && sram.sram_data_ok && !flush_i;
    resp_rdata_o = resp_valid_o && !we_q ? rext : '0;
    adel_o       = idle && req_valid_i && !flush_i && !aligned && !req_we_i;
    ades_o       = idle && req_valid_i && !flush_i && !aligned && req_we_i;
    bad_vaddr_o  = adel_o || ades_o ? req_addr_i : '0;
    sram.sram_req = state_q == DM_REQ;
  end
  assign sram.sram_wr    = we_q;
  assign sram.sram_size  = size_q;
  assign sram.sram_addr  = addr_q;
  assign sram.sram_wstrb = wstrb_q;
  assign sram.sram_wdata = wdata_q;
endmodule
